// File: rtl/pixel_frame_src.sv
// Test-pattern pixel source: emits IMG_WIDTH x IMG_HEIGHT 8-bit frames over a
// registered valid/ready stream, with sof/eol/eof markers and a run frame count.
module pixel_frame_src #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] pattern,
  input  logic [7:0] seed,
  input  logic [3:0] frames,
  output logic [7:0] pixel_out,
  output logic       VALID_OUT,
  input  logic       READY_IN,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic       busy,
  output logic       done,
  output logic [3:0] frame_cnt
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    lfsr;
  logic [1:0]    pat_q;
  logic [7:0]    seed_q;
  logic [3:0]    frames_q;

  logic [RW-1:0] row_nx;
  logic [CW-1:0] col_nx;
  logic [7:0]    lfsr_nx;
  logic [7:0]    lfsr_init;
  logic [3:0]    frame_cnt_nx;
  logic          last_col;
  logic          last_row;
  logic          run_over;

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    lfsr_step = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Masking with a cast 4 yields 0 when the counter has no bit 2 (tiny frames).
  function automatic logic [7:0] pix_calc(input logic [1:0]    pat,
                                          input logic [7:0]    sd,
                                          input logic [RW-1:0] r,
                                          input logic [CW-1:0] c,
                                          input logic [7:0]    lf);
    case (pat)
      2'b00:   pix_calc = 8'(r) + 8'(c) + sd;
      2'b01:   pix_calc = ((|(r & RW'(4))) ^ (|(c & CW'(4)))) ? 8'hFF : 8'h00;
      2'b10:   pix_calc = lf;
      default: pix_calc = sd;
    endcase
  endfunction

  always_comb begin
    last_col     = (col == CW'(IMG_WIDTH - 1));
    last_row     = (row == RW'(IMG_HEIGHT - 1));
    col_nx       = last_col ? '0 : col + CW'(1);
    row_nx       = row;
    if (last_col) row_nx = last_row ? '0 : row + RW'(1);
    lfsr_nx      = lfsr_step(lfsr);
    lfsr_init    = (seed == 8'h00) ? 8'h01 : seed;
    frame_cnt_nx = frame_cnt + 4'd1;
    run_over     = ((frames_q != 4'd0) && (frame_cnt_nx == frames_q)) || !start;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      lfsr      <= 8'h01;
      pat_q     <= '0;
      seed_q    <= '0;
      frames_q  <= '0;
      pixel_out <= '0;
      VALID_OUT <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          VALID_OUT <= 1'b0;
          if (start) begin
            pat_q     <= pattern;
            seed_q    <= seed;
            frames_q  <= frames;
            row       <= '0;
            col       <= '0;
            frame_cnt <= '0;
            lfsr      <= lfsr_init;
            pixel_out <= pix_calc(pattern, seed, '0, '0, lfsr_init);
            sof       <= 1'b1;
            eol       <= 1'b0;
            eof       <= 1'b0;
            VALID_OUT <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          if (VALID_OUT && READY_IN) begin
            row       <= row_nx;
            col       <= col_nx;
            lfsr      <= lfsr_nx;
            pixel_out <= pix_calc(pat_q, seed_q, row_nx, col_nx, lfsr_nx);
            sof       <= (row_nx == '0) && (col_nx == '0);
            eol       <= (col_nx == CW'(IMG_WIDTH - 1));
            eof       <= (row_nx == RW'(IMG_HEIGHT - 1)) && (col_nx == CW'(IMG_WIDTH - 1));
            if (eof) begin
              frame_cnt <= frame_cnt_nx;
              // A frame in progress always finishes; the stop decision is only made here.
              if (run_over) begin
                VALID_OUT <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                sof       <= 1'b0;
                eol       <= 1'b0;
                eof       <= 1'b0;
                state     <= DONE;
              end
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          VALID_OUT <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_src.sv
// Self-checking bench for pixel_frame_src: randomized backpressure, all four
// patterns, run/stop behaviour and reset, against a position-based pixel model.
module tb_pixel_frame_src;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int FP = W * H;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       ready_in = 1'b0;
  logic [1:0] pattern = 2'b00;
  logic [7:0] seed = 8'h00;
  logic [3:0] frames = 4'd0;
  logic [7:0] pixel_out;
  logic       valid_out, sof, eol, eof, busy, done;
  logic [3:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  logic [1:0] m_pat;
  logic [7:0] m_seed;
  logic [7:0] m_lfsr;
  logic [7:0] beat_pix [0:4095];
  logic [2:0] beat_mk  [0:4095];

  always #5 clk = ~clk;

  pixel_frame_src #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .pattern   (pattern),
    .seed      (seed),
    .frames    (frames),
    .pixel_out (pixel_out),
    .VALID_OUT (valid_out),
    .READY_IN  (ready_in),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  // Reference: pixel k of the run sits at row (k mod FP)/W, col k mod W.
  function automatic logic [7:0] exp_pix(input int k);
    int idx, r, c;
    idx = k % FP;
    r = idx / W;
    c = idx % W;
    case (m_pat)
      2'b00:   return 8'((r + c + int'(m_seed)) % 256);
      2'b01:   return ((((r / 4) + (c / 4)) % 2) == 1) ? 8'hFF : 8'h00;
      2'b10:   return m_lfsr;
      default: return m_seed;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic start_run(input logic [1:0] pat, input logic [7:0] sd, input logic [3:0] frm);
    @(negedge clk);
    pattern  = pat;
    seed     = sd;
    frames   = frm;
    start    = 1'b1;
    ready_in = 1'b1;
    m_pat    = pat;
    m_seed   = sd;
    m_lfsr   = (sd == 8'h00) ? 8'h01 : sd;
  endtask

  // Consumes one run until done, comparing every accepted beat against the model.
  task automatic drain_run(input string tag, input int budget, input bit rnd, input int drop_at,
                           output int n_xfer, output int n_sof);
    logic [7:0] hp;
    logic [2:0] hm;
    logic       hv;
    logic [7:0] ep;
    logic [2:0] em;
    bit         stall, got_done;
    int         idx;
    n_xfer = 0; n_sof = 0; stall = 0; got_done = 0;
    hp = '0; hm = '0; hv = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if ({valid_out, busy, sof} !== 3'b111) begin
          errors++;
          $display("FAIL %s start_latency: valid/busy/sof=%b required 111", tag, {valid_out, busy, sof});
        end
      end
      if (stall) begin
        checks++;
        if ({pixel_out, sof, eol, eof, valid_out} !== {hp, hm, hv}) begin
          errors++;
          $display("FAIL %s hold: outputs=%h required %h", tag,
                   {pixel_out, sof, eol, eof, valid_out}, {hp, hm, hv});
        end
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (!rnd) begin
        checks++;
        if (valid_out !== 1'b1) begin
          errors++;
          $display("FAIL %s bubble: valid_out=%b required 1 at beat %0d", tag, valid_out, n_xfer);
        end
      end
      if (drop_at >= 0 && n_xfer >= drop_at) start = 1'b0;
      ready_in = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (valid_out && ready_in) begin
        idx = n_xfer % FP;
        ep = exp_pix(n_xfer);
        em = {idx == 0, (idx % W) == W - 1, idx == FP - 1};
        checks++;
        if ({pixel_out, sof, eol, eof} !== {ep, em}) begin
          errors++;
          $display("FAIL %s beat%0d: pix/sof/eol/eof=%h/%b got, required %h/%b",
                   tag, n_xfer, pixel_out, {sof, eol, eof}, ep, em);
        end
        if (n_xfer < 4096) begin
          beat_pix[n_xfer] = pixel_out;
          beat_mk[n_xfer]  = {sof, eol, eof};
        end
        if (sof) n_sof++;
        n_xfer++;
        m_lfsr = lfsr_next(m_lfsr);
      end
      stall = valid_out && !ready_in;
      hp = pixel_out; hm = {sof, eol, eof}; hv = valid_out;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s timeout: done not seen within %0d cycles, transfers=%0d", tag, budget, n_xfer);
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    checks++;
    if ({done, valid_out, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_done: done/valid/busy=%b required 000", tag, {done, valid_out, busy});
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pixel_out, valid_out, sof, eol, eof} !== 12'h000) begin
      errors++;
      $display("FAIL reset_data: pix/valid/markers=%h required 000", {pixel_out, valid_out, sof, eol, eof});
    end
    checks++;
    if ({busy, done, frame_cnt} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status: busy/done/frame_cnt=%b required 0", {busy, done, frame_cnt});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: valid_out=%b required 0", valid_out);
    end
  endtask

  task automatic test_ramp;
    int n, ns;
    start_run(2'b00, 8'h00, 4'd1);
    drain_run("ramp", 1100, 0, -1, n, ns);
    start = 1'b0;
    checks++;
    if (n != 1024) begin errors++; $display("FAIL ramp_count: transfers=%0d required 1024", n); end
    checks++;
    if (frame_cnt !== 4'd1) begin errors++; $display("FAIL ramp_frame_cnt: %0d required 1", frame_cnt); end
    checks++;
    if ({beat_pix[0], beat_mk[0]} !== {8'd0, 3'b100}) begin
      errors++; $display("FAIL ramp_first: %h/%b required 00/100", beat_pix[0], beat_mk[0]);
    end
    checks++;
    if ({beat_pix[31], beat_mk[31]} !== {8'd31, 3'b010}) begin
      errors++; $display("FAIL ramp_eol: %0d/%b required 31/010", beat_pix[31], beat_mk[31]);
    end
    checks++;
    if (beat_pix[32] !== 8'd1) begin errors++; $display("FAIL ramp_row1: %0d required 1", beat_pix[32]); end
    checks++;
    if ({beat_pix[1023], beat_mk[1023]} !== {8'd62, 3'b011}) begin
      errors++; $display("FAIL ramp_eof: %0d/%b required 62/011", beat_pix[1023], beat_mk[1023]);
    end
    expect_idle("ramp");
  endtask

  task automatic test_lfsr;
    logic [7:0] want [0:4];
    logic [7:0] sd;
    int n, ns;
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h04; want[3] = 8'h08; want[4] = 8'h11;
    for (int s = 0; s < 2; s++) begin
      sd = 8'(s);
      start_run(2'b10, sd, 4'd1);
      drain_run("lfsr", 1100, 0, -1, n, ns);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (beat_pix[i] !== want[i]) begin
          errors++;
          $display("FAIL lfsr_seed%0d_beat%0d: %h required %h", s, i, beat_pix[i], want[i]);
        end
      end
      checks++;
      if (n != 1024) begin errors++; $display("FAIL lfsr_count: transfers=%0d required 1024", n); end
      expect_idle("lfsr");
    end
  endtask

  task automatic test_backpressure;
    int n, ns;
    start_run(2'b01, 8'h3C, 4'd1);
    drain_run("bp", 4000, 1, -1, n, ns);
    start = 1'b0;
    ready_in = 1'b1;
    checks++;
    if (n != 1024) begin errors++; $display("FAIL bp_count: transfers=%0d required 1024", n); end
    checks++;
    if (beat_pix[4] !== 8'hFF) begin errors++; $display("FAIL bp_0_4: %h required FF", beat_pix[4]); end
    checks++;
    if (beat_pix[132] !== 8'h00) begin errors++; $display("FAIL bp_4_4: %h required 00", beat_pix[132]); end
    expect_idle("bp");
  endtask

  task automatic test_continuous;
    int n, ns;
    start_run(2'b00, 8'h10, 4'd0);
    drain_run("cont", 3300, 0, 2048 + 300, n, ns);
    checks++;
    if (n != 3072) begin errors++; $display("FAIL cont_count: transfers=%0d required 3072", n); end
    checks++;
    if (ns != 3 || beat_mk[1024][2] !== 1'b1 || beat_mk[2048][2] !== 1'b1) begin
      errors++; $display("FAIL cont_sof: sof count=%0d required 3 at 0,1024,2048", ns);
    end
    checks++;
    if (frame_cnt !== 4'd3) begin errors++; $display("FAIL cont_frame_cnt: %0d required 3", frame_cnt); end
    expect_idle("cont");
  endtask

  task automatic test_back_to_back;
    int n, ns;
    start_run(2'b00, 8'h07, 4'd2);
    drain_run("frames2", 2200, 0, -1, n, ns);
    checks++;
    if (n != 2048 || frame_cnt !== 4'd2) begin
      errors++; $display("FAIL frames2_count: transfers=%0d frame_cnt=%0d required 2048/2", n, frame_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done, valid_out, busy, frame_cnt} !== {3'b000, 4'd2}) begin
      errors++; $display("FAIL frames2_idle: done/valid/busy/frame_cnt=%b required 0000010", {done, valid_out, busy, frame_cnt});
    end
    @(negedge clk);
    checks++;
    if ({valid_out, sof, pixel_out, frame_cnt} !== {2'b11, 8'h07, 4'd0}) begin
      errors++; $display("FAIL frames2_restart: valid/sof/pix/frame_cnt=%b/%b/%h/%0d required 1/1/07/0",
                         valid_out, sof, pixel_out, frame_cnt);
    end
    start = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid;
    start_run(2'b11, 8'hA5, 4'd0);
    repeat (100) @(negedge clk);
    checks++;
    if ({valid_out, pixel_out} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL const_mid: valid/pix=%b/%h required 1/A5", valid_out, pixel_out);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({pixel_out, valid_out, sof, eol, eof, busy, done, frame_cnt} !== 18'd0) begin
      errors++; $display("FAIL reset_mid: outputs=%h required 0",
                         {pixel_out, valid_out, sof, eol, eof, busy, done, frame_cnt});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid_out, sof, pixel_out} !== {2'b11, 8'hA5}) begin
      errors++; $display("FAIL reset_restart: valid/sof/pix=%b/%b/%h required 1/1/A5", valid_out, sof, pixel_out);
    end
    start = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_lfsr();
    test_backpressure();
    test_continuous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
